// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode encodings and FSM state type for the sequential ALU.
package seq_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_core.sv
// alu_comb_core: purely combinational single-cycle ops (AND/OR/ADD/SUB/SLT)
// with carry and, when SEQ_ALU_OVF_EN is defined, signed overflow.
// Shift and multiply opcodes produce all-zero outputs here; the sequential
// wrapper handles them iteratively.
module alu_comb_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             set_o,
  output logic             carry_o
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic           slt_s;

  // Subtraction as a + ~b + 1 so the carry-out is the inverted borrow.
  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign slt_s  = ($signed(a_i) < $signed(b_i));

  // Select result and flags for the requested single-cycle operation.
  always_comb begin
    result_o = '0;
    set_o    = 1'b0;
    carry_o  = 1'b0;
`ifdef SEQ_ALU_OVF_EN
    ovf_o    = 1'b0;
`endif
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_ADD: begin
        result_o = sum_s[WIDTH-1:0];
        carry_o  = sum_s[WIDTH];
`ifdef SEQ_ALU_OVF_EN
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        result_o = diff_s[WIDTH-1:0];
        carry_o  = diff_s[WIDTH];
`ifdef SEQ_ALU_OVF_EN
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
`endif
      end
      OP_SLT: begin
        result_o = {{(WIDTH-1){1'b0}}, slt_s};
        set_o    = slt_s;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Single-cycle ops complete in one cycle; shifts
// step one bit per cycle and multiply is shift-add over WIDTH cycles.
// Optional feature macro: SEQ_ALU_OVF_EN (adds registered signed-overflow output ovf_o).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [2:0]       opcode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] alu_result_o,
  output logic             set_o,
  output logic             zero_o,
  output logic             carry_o
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               set_q, set_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
`ifdef SEQ_ALU_OVF_EN
  logic               ovf_q, ovf_d;
  logic               core_ovf_s;
`endif

  logic [WIDTH-1:0]   core_res_s;
  logic               core_set_s;
  logic               core_carry_s;
  logic [WIDTH-1:0]   step_s;
  logic [SHAMT_W-1:0] shamt_s;

  assign shamt_s = rt_i[SHAMT_W-1:0];

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (rs_i),
    .b_i      (rt_i),
    .op_i     (opcode_i),
    .result_o (core_res_s),
    .set_o    (core_set_s),
    .carry_o  (core_carry_s)
`ifdef SEQ_ALU_OVF_EN
    ,
    .ovf_o    (core_ovf_s)
`endif
  );

  // One iteration of the working register: a 1-bit shift or a shift-add step.
  always_comb begin
    step_s = acc_q;
    case (op_q)
      OP_SLL:  step_s = acc_q << 1;
      OP_SRL:  step_s = acc_q >> 1;
      OP_MUL:  step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      default: step_s = acc_q;
    endcase
  end

  // Next-state logic for FSM, counter, iterative datapath and result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    set_d    = set_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`ifdef SEQ_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d = opcode_i;
          case (opcode_i)
            OP_SLL, OP_SRL: begin
              if (shamt_s == '0) begin
                // Zero shift amount: pass rs straight to the result.
                res_d   = rs_i;
                zero_d  = (rs_i == '0);
                set_d   = 1'b0;
                carry_d = 1'b0;
`ifdef SEQ_ALU_OVF_EN
                ovf_d   = 1'b0;
`endif
                cnt_d   = '0;
                state_d = DONE;
              end else begin
                acc_d   = rs_i;
                cnt_d   = {1'b0, shamt_s};
                state_d = BUSY;
              end
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = rs_i;
              mplier_d = rt_i;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = BUSY;
            end
            default: begin
              res_d   = core_res_s;
              zero_d  = (core_res_s == '0);
              set_d   = core_set_s;
              carry_d = core_carry_s;
`ifdef SEQ_ALU_OVF_EN
              ovf_d   = core_ovf_s;
`endif
              state_d = DONE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d    = step_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = step_s;
          zero_d  = (step_s == '0);
          set_d   = 1'b0;
          carry_d = 1'b0;
`ifdef SEQ_ALU_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_AND;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      set_q    <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      set_q    <= set_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);
  assign alu_result_o = res_q;
  assign set_o        = set_q;
  assign zero_o       = zero_q;
  assign carry_o      = carry_q;
`ifdef SEQ_ALU_OVF_EN
  assign ovf_o        = ovf_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu with an arithmetic
// reference model, a per-cycle output compare process and literal pins.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs, rt;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             set_f, zero_f, carry_f;
`ifdef SEQ_ALU_OVF_EN
  logic             ovf_f;
`endif

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .rs_i         (rs),
    .rt_i         (rt),
    .opcode_i     (opcode),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .alu_result_o (alu_result),
    .set_o        (set_f),
    .zero_o       (zero_f),
    .carry_o      (carry_f)
`ifdef SEQ_ALU_OVF_EN
    ,
    .ovf_o        (ovf_f)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             set;
    logic             zero;
    logic             carry;
    logic             ovf;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_cur;
  logic exp_live = 1'b0;
  logic [WIDTH-1:0] cap_res;
  logic cap_set, cap_zero, cap_carry;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int unsigned ua, ub, full;
    int sa, sb, s;
    int lim;
    ua  = a;
    ub  = b;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    lim = 1 << (WIDTH - 1);
    e   = '0;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_ADD: begin
        full    = ua + ub;
        e.res   = full[WIDTH-1:0];
        e.carry = (full >= (32'd1 << WIDTH));
        s       = sa + sb;
        e.ovf   = (s >= lim) || (s < -lim);
      end
      OP_SUB: begin
        full    = ua - ub;
        e.res   = full[WIDTH-1:0];
        e.carry = (ua >= ub);
        s       = sa - sb;
        e.ovf   = (s >= lim) || (s < -lim);
      end
      OP_SLT: begin
        e.set = (sa < sb);
        e.res = (sa < sb) ? WIDTH'(1) : WIDTH'(0);
      end
      OP_SLL: e.res = WIDTH'(a << b[SHAMT_W-1:0]);
      OP_SRL: e.res = WIDTH'(a >> b[SHAMT_W-1:0]);
      default: begin
        full  = ua * ub;
        e.res = full[WIDTH-1:0];
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(b[SHAMT_W-1:0]);
    if (op == OP_MUL) return WIDTH + 1;
    else if ((op == OP_SLL || op == OP_SRL) && sh != 0) return sh + 1;
    else return 1;
  endfunction

  // Every cycle the DUT presents a result, it must match the model exactly.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_live) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("cmp_result", 32'(alu_result), 32'(exp_cur.res));
        chk("cmp_set",    32'(set_f),      32'(exp_cur.set));
        chk("cmp_zero",   32'(zero_f),     32'(exp_cur.zero));
        chk("cmp_carry",  32'(carry_f),    32'(exp_cur.carry));
`ifdef SEQ_ALU_OVF_EN
        chk("cmp_ovf",    32'(ovf_f),      32'(exp_cur.ovf));
`endif
        chk("cmp_in_ready_low", 32'(in_ready), 32'd0);
      end
    end
  end

  // Present one operation and let the DUT accept it on the next rising edge.
  task automatic start_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode   = op;
    rs       = a;
    rt       = b;
    @(posedge clk);
    #1;
    exp_cur  = model(op, a, b);
    exp_live = 1'b1;
    // Keep in_valid high with different operands: must be ignored while busy.
    opcode   = ~op;
    rs       = ~a;
    rt       = ~b;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    int lat;
    out_ready = (hold == 0);
    start_op(op, a, b);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_while_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(model_lat(op, b)));
    cap_res   = alu_result;
    cap_set   = set_f;
    cap_zero  = zero_f;
    cap_carry = carry_f;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("held_valid", 32'(out_valid), 32'd1);
      chk("held_result", 32'(alu_result), 32'(cap_res));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consumed_valid_low", 32'(out_valid), 32'd0);
    chk("consumed_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    exp_live  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rs        = '0;
    rt        = '0;
    opcode    = OP_AND;
    #2;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_result",    32'(alu_result), 32'd0);
    chk("rst_flags",     32'({set_f, zero_f, carry_f}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the reference model against hand-computed values.
    chk("pin_add", 32'(model(OP_ADD, 8'h7F, 8'h01)), 32'({8'h80, 1'b0, 1'b0, 1'b0, 1'b1}));
    chk("pin_mul", 32'(model(OP_MUL, 8'h0F, 8'h11).res), 32'h0000_00FF);
    chk("pin_sub_borrow", 32'(model(OP_SUB, 8'h01, 8'h02)), 32'({8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}));

    run_op(OP_ADD, 8'h7F, 8'h01, 0);
    chk("add_res", 32'(cap_res), 32'h80);
    chk("add_zc",  32'({cap_zero, cap_carry}), 32'd0);

    run_op(OP_SUB, 8'h05, 8'h05, 0);
    chk("sub_res",  32'(cap_res), 32'h00);
    chk("sub_flags", 32'({cap_set, cap_zero, cap_carry}), 32'b011);

    run_op(OP_SLT, 8'hFE, 8'h01, 0);
    chk("slt_true", 32'({cap_res, cap_set}), 32'({8'h01, 1'b1}));
    run_op(OP_SLT, 8'h01, 8'hFE, 0);
    chk("slt_false", 32'({cap_res, cap_set, cap_zero}), 32'({8'h00, 1'b0, 1'b1}));

    run_op(OP_MUL, 8'h0F, 8'h11, 3);
    chk("mul_res", 32'(cap_res), 32'hFF);

    run_op(OP_SLL, 8'h01, 8'h07, 0);
    chk("sll_res", 32'(cap_res), 32'h80);
    run_op(OP_SRL, 8'h80, 8'h00, 0);
    chk("srl0_res", 32'(cap_res), 32'h80);

    run_op(OP_ADD, 8'hFF, 8'h01, 0);
    chk("add_wrap", 32'({cap_res, cap_zero, cap_carry}), 32'({8'h00, 1'b1, 1'b1}));
    run_op(OP_SUB, 8'h01, 8'h02, 1);
    run_op(OP_OR,  8'hA0, 8'h0A, 0);
    run_op(OP_SRL, 8'hF0, 8'h0B, 2);
    run_op(OP_MUL, 8'hFF, 8'hFF, 0);
    chk("mul_wrap", 32'(cap_res), 32'h01);
    run_op(OP_SUB, 8'h80, 8'h01, 0);

    // Reset in the fourth BUSY cycle of a multiply discards it.
    out_ready = 1'b1;
    start_op(OP_MUL, 8'h33, 8'h05);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mul_busy_before_reset", 32'({in_ready, out_valid}), 32'd0);
    rst_n = 1'b0;
    #1;
    exp_live = 1'b0;
    chk("midrst_result",   32'(alu_result), 32'd0);
    chk("midrst_flags",    32'({set_f, zero_f, carry_f}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready),   32'd1);
    chk("midrst_valid",    32'(out_valid),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(OP_AND, 8'h55, 8'hAA, 0);
    chk("and_after_reset", 32'({cap_res, cap_zero}), 32'({8'h00, 1'b1}));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU in the processor datapath. WIDTH-bit operands are accepted on a valid/ready input port. Single-cycle logic and arithmetic ops return in one cycle. Shifts and multiply run iteratively, one step per cycle. The registered result and flags are held on a valid/ready output port until consumed.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHAMT_W, $clog2(WIDTH), derived localparam; shift-amount width taken from rt_i[SHAMT_W-1:0]

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
in_valid_i  in  1  operands/opcode valid
in_ready_o  out  1  block can accept an operation
rs_i  in  WIDTH  operand A
rt_i  in  WIDTH  operand B / shift amount
opcode_i  in  3  operation select
out_valid_o  out  1  result/flags valid
out_ready_i  in  1  consumer takes result
alu_result_o  out  WIDTH  registered result
set_o  out  1  SLT outcome
zero_o  out  1  alu_result_o == 0
carry_o  out  1  carry-out of ADD/SUB

Behaviour:
- Opcodes: 000 AND; 001 OR; 010 ADD; 011 SUB (rs-rt); 100 SLT (signed rs<rt, result = {0..,1} or 0); 101 SLL rs by rt[SHAMT_W-1:0]; 110 SRL (logical), same shift amount; 111 MUL (low WIDTH bits of rs*rt).
- FSM states:
  - IDLE: in_ready_o=1.
  - BUSY: iterating, in_ready_o=0.
  - DONE: out_valid_o=1, in_ready_o=0.
- IDLE, in_valid_i=1: operands and opcode latched.
  - AND/OR/ADD/SUB/SLT: result and flags registered; next state DONE. out_valid_o high the cycle after acceptance (latency 1).
  - SLL/SRL with shamt=0: rs registered unchanged; next state DONE (latency 1).
  - SLL/SRL with shamt=N>0: counter loaded with N; next state BUSY. One bit shifted per cycle; DONE after N BUSY cycles (latency N+1).
  - MUL: shift-add, counter loaded with WIDTH; one multiplier bit per cycle; DONE after WIDTH cycles (latency WIDTH+1). Product is unsigned; low WIDTH bits kept, overflow bits discarded.
- DONE: alu_result_o and all flags held stable while out_ready_i=0. When out_ready_i=1, go to IDLE next cycle; out_valid_o drops. No new acceptance in the same cycle: peak throughput is one op per 2 cycles.
- Flags:
  - set_o: 1 only for SLT-true; 0 for every other op.
  - carry_o: ADD carry-out; SUB carry = NOT borrow (rs>=rt unsigned gives 1); 0 for every other op.
  - zero_o: registered alongside the result, valid whenever out_valid_o=1.
- in_valid_i while not IDLE is ignored; upstream must hold it until in_ready_o=1.
- Reset (any time, including mid-BUSY or DONE): state=IDLE; alu_result_o=0; set_o=0; zero_o=0; carry_o=0; out_valid_o=0; counter=0; in-flight op discarded. in_ready_o=1 while in reset and after release.
- Invalid/unreachable FSM encodings return to IDLE.

Optional Feature:
SEQ_ALU_OVF_EN
- Defined: adds output port ovf_o (1 bit) = signed overflow of ADD/SUB, registered with the result and reset to 0; 0 for all other ops.
- Undefined: port and logic absent; other behaviour identical.

Decomposition:
- Package seq_alu_pkg: opcode localparams (OP_AND..OP_MUL, 3-bit) and FSM state typedef (IDLE, BUSY, DONE).
- One sub-module, alu_comb_core: purely combinational AND/OR/ADD/SUB/SLT plus carry and overflow. seq_alu holds the FSM, counter, and iterative shift/multiply datapath.

Test Plan:
- ADD rs=8'h7F, rt=8'h01, out_ready_i=1 -> out_valid_o 1 cycle after accept; result 8'h80, zero_o=0, carry_o=0; ovf_o=1 when SEQ_ALU_OVF_EN is defined.
- SUB rs=8'h05, rt=8'h05 -> result 8'h00, zero_o=1, carry_o=1, set_o=0.
- SLT rs=8'hFE (-2), rt=8'h01 -> result 8'h01, set_o=1; then SLT rs=8'h01, rt=8'hFE -> result 8'h00, set_o=0, zero_o=1.
- MUL rs=8'h0F, rt=8'h11, out_ready_i=0 for 3 cycles after out_valid_o rises -> out_valid_o at cycle 9 after accept; result 8'hFF held stable; in_ready_o=0 until the cycle after out_ready_i=1.
- SLL rs=8'h01, rt=8'h07 -> result 8'h80 at latency 8; SRL rs=8'h80, rt=8'h00 -> result 8'h80 at latency 1.
- Pulse rst_n_i low during MUL BUSY cycle 4 -> all outputs 0 immediately, in_ready_o=1; a following AND 8'h55 & 8'hAA completes normally with result 8'h00, zero_o=1.
